// File: rtl/mac_rx_pkt_buffer.sv
// Store-and-forward MAC receive buffer: framing/length checks, speculative write with rewind, valid/ready output.
// Optional statistics counters are built when MAC_RX_BUF_STATS_EN is defined.
module mac_rx_pkt_buffer #(
    parameter int DEPTH     = 512,
    parameter int MIN_BYTES = 64,
    parameter int MAX_BYTES = 1518
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rx_data,
    input  logic [1:0]  rx_bv,
    input  logic        rx_valid,
    input  logic        rx_sop,
    input  logic        rx_eop,
    output logic [31:0] out_data,
    output logic [1:0]  out_bv,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    input  logic        out_ready,
    output logic [15:0] pkt_cnt,
    output logic [15:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [15:0]   MIN_L    = 16'(MIN_BYTES);
    localparam logic [15:0]   MAX_L    = 16'(MAX_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    function automatic logic [2:0] word_bytes(input logic eop, input logic [1:0] bv);
        logic [2:0] n;
        if (!eop) begin
            n = 3'd4;
        end else begin
            case (bv)
                2'b01:   n = 3'd1;
                2'b10:   n = 3'd2;
                2'b11:   n = 3'd3;
                default: n = 3'd4;
            endcase
        end
        return n;
    endfunction

    logic [35:0]   r_mem [DEPTH];
    state_t        r_state;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_cm_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [15:0]   r_byte_cnt;
    logic [31:0]   r_out_data;
    logic [1:0]    r_out_bv;
    logic          r_out_valid;
    logic          r_out_sop;
    logic          r_out_eop;

    logic          w_sop_word;
    logic          w_cont_word;
    logic          w_word;
    logic [PW-1:0] w_base;
    logic          w_full;
    logic          w_wr_en;
    logic [2:0]    w_bytes;
    logic [15:0]   w_cnt_new;
    logic          w_len_ok;
    logic          w_commit;
    logic          w_abort;
    logic [1:0]    w_bv_store;
    logic          w_rd_load;
    logic [35:0]   w_rd_word;

    // A sop always restarts at the commit pointer, which also rewinds any unfinished packet.
    assign w_sop_word  = rx_valid & rx_sop;
    assign w_cont_word = rx_valid & ~rx_sop & (r_state == ST_RECV);
    assign w_word      = w_sop_word | w_cont_word;
    assign w_base      = w_cont_word ? r_wr_ptr : r_cm_ptr;
    assign w_full      = ((w_base - r_rd_ptr) == DEPTH_P);
    assign w_wr_en     = w_word & ~w_full & reset;
    assign w_bytes     = word_bytes(rx_eop, rx_bv);
    assign w_cnt_new   = (w_cont_word ? r_byte_cnt : 16'd0) + {13'd0, w_bytes};
    assign w_len_ok    = (w_cnt_new >= MIN_L) && (w_cnt_new <= MAX_L);
    assign w_commit    = w_word & ~w_full & rx_eop & w_len_ok;
    assign w_abort     = w_word & (w_full | (rx_eop ? ~w_len_ok : (w_cnt_new > MAX_L)));
    assign w_bv_store  = rx_eop ? rx_bv : 2'b00;

    // Packet storage write port.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_base[AW-1:0]] <= {rx_sop, rx_eop, w_bv_store, rx_data};
        end
    end

    // Receive FSM with speculative write pointer and commit pointer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_cm_ptr   <= '0;
            r_byte_cnt <= 16'd0;
        end else if (w_word) begin
            r_byte_cnt <= w_cnt_new;
            if (w_abort) begin
                r_wr_ptr <= r_cm_ptr;
                r_state  <= rx_eop ? ST_IDLE : ST_DROP;
            end else if (w_commit) begin
                r_wr_ptr <= w_base + PTR_ONE;
                r_cm_ptr <= w_base + PTR_ONE;
                r_state  <= ST_IDLE;
            end else begin
                r_wr_ptr <= w_base + PTR_ONE;
                r_state  <= ST_RECV;
            end
        end else if (rx_valid && rx_eop && (r_state == ST_DROP)) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= r_state;
        end
    end

    assign w_rd_load = (r_rd_ptr != r_cm_ptr) && (!r_out_valid || out_ready);
    assign w_rd_word = r_mem[r_rd_ptr[AW-1:0]];

    // Output stage: only committed words are ever read; it holds while stalled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr    <= '0;
            r_out_data  <= 32'd0;
            r_out_bv    <= 2'b00;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
        end else if (w_rd_load) begin
            r_rd_ptr    <= r_rd_ptr + PTR_ONE;
            r_out_sop   <= w_rd_word[35];
            r_out_eop   <= w_rd_word[34];
            r_out_bv    <= w_rd_word[33:32];
            r_out_data  <= w_rd_word[31:0];
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_data  = r_out_data;
    assign out_bv    = r_out_bv;
    assign out_valid = r_out_valid;
    assign out_sop   = r_out_sop;
    assign out_eop   = r_out_eop;

`ifdef MAC_RX_BUF_STATS_EN
    logic [15:0] r_pkt_cnt;
    logic [15:0] r_drop_cnt;
    logic        w_drop_prev;
    logic [1:0]  w_drop_inc;

    // A mid-packet sop and an abort of the new word can both drop in one cycle.
    assign w_drop_prev = w_sop_word & (r_state == ST_RECV);
    assign w_drop_inc  = {1'b0, w_drop_prev} + {1'b0, w_abort};

    // Saturating good/drop packet counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pkt_cnt  <= 16'd0;
            r_drop_cnt <= 16'd0;
        end else begin
            if (w_commit && (r_pkt_cnt != 16'hFFFF)) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
            if (r_drop_cnt > (16'hFFFF - {14'd0, w_drop_inc})) begin
                r_drop_cnt <= 16'hFFFF;
            end else begin
                r_drop_cnt <= r_drop_cnt + {14'd0, w_drop_inc};
            end
        end
    end

    assign pkt_cnt  = r_pkt_cnt;
    assign drop_cnt = r_drop_cnt;
`else
    assign pkt_cnt  = 16'd0;
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mac_rx_pkt_buffer.sv
// Scoreboard bench for mac_rx_pkt_buffer: packet fate predicted from length/framing rules, output checked by a monitor.
module tb_mac_rx_pkt_buffer;

    localparam int DEPTH = 16;
    localparam int MIN_B = 8;
    localparam int MAX_B = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rx_data;
    logic [1:0]  rx_bv;
    logic        rx_valid, rx_sop, rx_eop;
    logic [31:0] out_data;
    logic [1:0]  out_bv;
    logic        out_valid, out_sop, out_eop;
    logic        out_ready;
    logic [15:0] pkt_cnt, drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q[$];
    int exp_pkt = 0;
    int exp_drop = 0;
    bit mon_en = 1'b0;
    bit rdy_rand = 1'b0;
    bit rdy_fix = 1'b1;

    mac_rx_pkt_buffer #(.DEPTH(DEPTH), .MIN_BYTES(MIN_B), .MAX_BYTES(MAX_B)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_bv(rx_bv), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
        .out_data(out_data), .out_bv(out_bv), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_ready(out_ready), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Downstream ready: fixed or random, changed just after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
        end
    end

    // Monitor: pops expected words on every handshake and checks stall stability.
    initial begin
        logic [35:0] cur, held, want;
        bit held_v;
        held_v = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            cur = {out_sop, out_eop, out_bv, out_data};
            if (mon_en) begin
                if (held_v) begin
                    checks++;
                    if (!out_valid || cur !== held) begin
                        errors++;
                        $display("FAIL stall_hold: got valid=%0b word=%h required valid=1 word=%h", out_valid, cur, held);
                    end
                end
                held_v = out_valid && !out_ready;
                held = cur;
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_out: got word=%h required no output", cur);
                    end else begin
                        want = exp_q.pop_front();
                        if (cur !== want) begin
                            errors++;
                            $display("FAIL out_word: got %h required %h", cur, want);
                        end
                    end
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    function automatic int nbytes(input logic [1:0] bv);
        return (bv == 2'b00) ? 4 : int'(bv);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        rx_sop = 1'b0;
        rx_eop = 1'b0;
        repeat (n) step();
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic check_cnts(input string tag);
`ifdef MAC_RX_BUF_STATS_EN
        chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkt));
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
`else
        chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'd0);
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
`endif
    endtask

    task automatic wait_q(input int limit, input string tag);
        int c;
        c = 0;
        while (exp_q.size() > limit && c < 3000) begin
            step();
            c++;
        end
        checks++;
        if (exp_q.size() > limit) begin
            errors++;
            $display("FAIL %s_timeout: got %0d words pending required at most %0d", tag, exp_q.size(), limit);
        end
    endtask

    // Send one packet; its fate comes from byte length and framing alone.
    task automatic send_pkt(input int n, input bit has_eop, input logic [1:0] ebv,
                            input bit gaps, input bit force_drop);
        logic [31:0] d[$];
        logic        s, e;
        logic [1:0]  b;
        int len;
        bit good;
        len = 4 * (n - 1) + (has_eop ? nbytes(ebv) : 4);
        good = has_eop && !force_drop && (len >= MIN_B) && (len <= MAX_B);
        for (int i = 0; i < n; i++) d.push_back($urandom);
        if (good) begin
            for (int i = 0; i < n; i++) begin
                s = (i == 0);
                e = (i == n - 1);
                b = e ? ebv : 2'b00;
                exp_q.push_back({s, e, b, d[i]});
            end
            exp_pkt++;
        end else begin
            exp_drop++;
        end
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            rx_valid = 1'b1;
            rx_sop = (i == 0);
            rx_eop = has_eop && (i == n - 1);
            rx_bv = rx_eop ? ebv : 2'($urandom);
            rx_data = d[i];
            step();
        end
        rx_valid = 1'b0;
        rx_sop = 1'b0;
        rx_eop = 1'b0;
    endtask

    initial begin
        bit open;
        int kind, n, k;
        reset = 1'b0;
        rx_data = 32'd0;
        rx_bv = 2'b00;
        rx_valid = 1'b0;
        rx_sop = 1'b0;
        rx_eop = 1'b0;
        repeat (3) step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_sop_eop", 64'({out_sop, out_eop}), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_bv", 64'(out_bv), 64'd0);
        chk("rst_cnts", 64'({pkt_cnt, drop_cnt}), 64'd0);
        reset = 1'b1;
        mon_en = 1'b1;
        step();

        // Good packet: latency and back-to-back output.
        send_pkt(3, 1'b1, 2'b10, 1'b0, 1'b0);
        chk("lat_before", 64'(out_valid), 64'd0);
        step();
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_sop", 64'(out_sop), 64'd1);
        step();
        step();
        chk("b2b_eop", 64'({out_valid, out_eop}), 64'd3);
        chk("b2b_bv", 64'(out_bv), 64'd2);
        wait_q(0, "good");
        idle(3);
        check_cnts("good");

        // Runt followed by a good packet.
        send_pkt(2, 1'b1, 2'b01, 1'b0, 1'b0);
        send_pkt(3, 1'b1, 2'b10, 1'b0, 1'b0);
        wait_q(0, "runt");
        idle(3);
        check_cnts("runt");

        // Missing eop, then a new 12-byte packet.
        send_pkt(4, 1'b0, 2'b00, 1'b0, 1'b0);
        send_pkt(3, 1'b1, 2'b00, 1'b0, 1'b0);
        wait_q(0, "noeop");
        idle(3);
        check_cnts("noeop");

        // Oversize: 11 words then eop.
        send_pkt(12, 1'b1, 2'b00, 1'b0, 1'b0);
        idle(5);
        chk("oversize_quiet", 64'(out_valid), 64'd0);
        check_cnts("oversize");

        // Overflow under backpressure.
        rdy_fix = 1'b0;
        idle(2);
        send_pkt(6, 1'b1, 2'b00, 1'b0, 1'b0);
        send_pkt(6, 1'b1, 2'b00, 1'b0, 1'b0);
        send_pkt(6, 1'b1, 2'b00, 1'b0, 1'b1);
        idle(5);
        chk("ovf_stalled", 64'({out_valid, out_sop}), 64'd3);
        check_cnts("overflow");
        rdy_fix = 1'b1;
        wait_q(0, "overflow");
        idle(5);

        // Reset during word 2 of a packet with output stalled.
        rdy_fix = 1'b0;
        idle(2);
        send_pkt(3, 1'b1, 2'b10, 1'b0, 1'b0);
        idle(3);
        rx_valid = 1'b1;
        rx_sop = 1'b1;
        rx_data = $urandom;
        step();
        rx_sop = 1'b0;
        rx_data = $urandom;
        mon_en = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_q.delete();
        exp_pkt = 0;
        exp_drop = 0;
        chk("rst2_valid", 64'(out_valid), 64'd0);
        chk("rst2_sop_eop", 64'({out_sop, out_eop}), 64'd0);
        chk("rst2_data", 64'(out_data), 64'd0);
        chk("rst2_bv", 64'(out_bv), 64'd0);
        chk("rst2_cnts", 64'({pkt_cnt, drop_cnt}), 64'd0);
        rx_eop = 1'b1;
        rx_bv = 2'b00;
        rx_data = $urandom;
        step();
        mon_en = 1'b1;
        rdy_fix = 1'b1;
        idle(10);
        chk("rst2_quiet", 64'(out_valid), 64'd0);
        send_pkt(3, 1'b1, 2'b11, 1'b0, 1'b0);
        wait_q(0, "post_reset");
        idle(3);
        check_cnts("post_reset");

        // Randomized traffic with random backpressure.
        rdy_rand = 1'b1;
        open = 1'b0;
        for (int p = 0; p < 200; p++) begin
            kind = $urandom_range(0, 9);
            wait_q(5, "rand_space");
            if (kind == 7 && !open) begin
                k = $urandom_range(1, 3);
                for (int j = 0; j < k; j++) begin
                    rx_valid = 1'b1;
                    rx_sop = 1'b0;
                    rx_eop = 1'($urandom_range(0, 1));
                    rx_bv = 2'($urandom);
                    rx_data = $urandom;
                    step();
                end
                idle($urandom_range(0, 2));
            end else if (kind == 6) begin
                n = $urandom_range(1, 13);
                send_pkt(n, 1'b0, 2'b00, 1'b1, 1'b0);
                open = 1'b1;
            end else begin
                n = $urandom_range(1, 12);
                send_pkt(n, 1'b1, 2'($urandom), 1'b1, 1'b0);
                open = 1'b0;
                idle($urandom_range(0, 2));
            end
        end
        send_pkt(3, 1'b1, 2'b00, 1'b1, 1'b0);
        rdy_rand = 1'b0;
        rdy_fix = 1'b1;
        wait_q(0, "final");
        idle(10);
        check_cnts("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
